// File: rtl/tlb_op_ctrl_pkg.sv
// Shared definitions for the TLB op controller: op codes, FSM states, CP0 field positions.
// Optional feature macro: TLB_WIRED_EN (adds the CP0 Wired bound on Random).
package tlb_op_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } tlb_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } tlb_state_e;

  // EntryHi / EntryLo field positions
  localparam int unsigned HI_VPN2_LSB = 13;
  localparam int unsigned HI_ASID_MSB = 7;
  localparam int unsigned LO_PFN_MSB  = 25;
  localparam int unsigned LO_PFN_LSB  = 6;
  localparam int unsigned LO_C_MSB    = 5;
  localparam int unsigned LO_C_LSB    = 3;
  localparam int unsigned LO_D_BIT    = 2;
  localparam int unsigned LO_V_BIT    = 1;
  localparam int unsigned LO_G_BIT    = 0;

  // Operand snapshot taken at accept; drives the TLB write/search ports
  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_random_cnt.sv
// CP0 Random counter: free-running down-counter over the replaceable TLB entries.
// With TLB_WIRED_EN the lower bound comes from CP0 Wired.
module tlb_random_cnt #(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
`ifdef TLB_WIRED_EN
  input  logic [IW-1:0] wired,
`endif
  output logic [IW-1:0] random
);

  localparam logic [IW-1:0] TOP = IW'(TLBNUM - 1);

`ifdef TLB_WIRED_EN
  logic [IW-1:0] wired_q;

  // Any Wired update restarts Random at the top of the range
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random  <= TOP;
      wired_q <= '0;
    end else begin
      wired_q <= wired;
      if ((wired != wired_q) || (wired >= TOP) || (random <= wired)) begin
        random <= TOP;
      end else begin
        random <= random - IW'(1);
      end
    end
  end
`else
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random <= TOP;
    end else if (random == '0) begin
      random <= TOP;
    end else begin
      random <= random - IW'(1);
    end
  end
`endif

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB op controller: runs TLBP/TLBR/TLBWI/TLBWR for WB with a fixed accept->done latency of 2.
// Optional feature macro: TLB_WIRED_EN (exposes cp0_wired to bound the Random counter).
module tlb_op_ctrl
  import tlb_op_ctrl_pkg::*;
#(
  parameter  int unsigned TLBNUM = 16,
  localparam int unsigned IW     = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          op_valid,
  input  logic [1:0]    op_code,
  output logic          op_ready,
  output logic          op_done,
  output logic          tlb_flush,
  input  logic [IW-1:0] cp0_index,
  input  logic [31:0]   cp0_entryhi,
  input  logic [31:0]   cp0_entrylo0,
  input  logic [31:0]   cp0_entrylo1,
`ifdef TLB_WIRED_EN
  input  logic [IW-1:0] cp0_wired,
`endif
  output logic [IW-1:0] cp0_random,
  output logic [18:0]   s1_vpn2,
  output logic          s1_odd_page,
  output logic [7:0]    s1_asid,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  output logic          we,
  output logic [IW-1:0] w_index,
  output logic [18:0]   w_vpn2,
  output logic [7:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_pfn0,
  output logic [2:0]    w_c0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_pfn1,
  output logic [2:0]    w_c1,
  output logic          w_d1,
  output logic          w_v1,
  output logic [IW-1:0] r_index,
  input  logic [18:0]   r_vpn2,
  input  logic [7:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_pfn0,
  input  logic [2:0]    r_c0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_pfn1,
  input  logic [2:0]    r_c1,
  input  logic          r_d1,
  input  logic          r_v1,
  output logic          wb_index_we,
  output logic          wb_index_p,
  output logic [IW-1:0] wb_index_idx,
  output logic          wb_entry_we,
  output logic [31:0]   wb_entryhi,
  output logic [31:0]   wb_entrylo0,
  output logic [31:0]   wb_entrylo1
);

  tlb_state_e    state;
  tlb_op_e       op_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] widx_q;
  tlb_entry_t    ent_q;

  // Reserved CP0 bits never reach the TLB
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{cp0_entryhi[HI_VPN2_LSB-1:HI_ASID_MSB+1],
                             cp0_entrylo0[31:LO_PFN_MSB+1], cp0_entrylo1[31:LO_PFN_MSB+1]};

  tlb_random_cnt #(.TLBNUM(TLBNUM)) u_random (
    .clk    (clk),
    .resetn (resetn),
`ifdef TLB_WIRED_EN
    .wired  (cp0_wired),
`endif
    .random (cp0_random)
  );

  // TLB port drives come straight from the accept-time snapshot
  assign s1_vpn2     = ent_q.vpn2;
  assign s1_asid     = ent_q.asid;
  assign s1_odd_page = 1'b0;
  assign r_index     = idx_q;
  assign w_index     = widx_q;
  assign w_vpn2      = ent_q.vpn2;
  assign w_asid      = ent_q.asid;
  assign w_g         = ent_q.g;
  assign w_pfn0      = ent_q.pfn0;
  assign w_c0        = ent_q.c0;
  assign w_d0        = ent_q.d0;
  assign w_v0        = ent_q.v0;
  assign w_pfn1      = ent_q.pfn1;
  assign w_c1        = ent_q.c1;
  assign w_d1        = ent_q.d1;
  assign w_v1        = ent_q.v1;

  // IDLE -> EXEC -> RESP -> IDLE; strobes default low so each lasts one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      op_ready     <= 1'b1;
      op_q         <= OP_TLBP;
      idx_q        <= '0;
      widx_q       <= '0;
      ent_q        <= '0;
      we           <= 1'b0;
      op_done      <= 1'b0;
      tlb_flush    <= 1'b0;
      wb_index_we  <= 1'b0;
      wb_index_p   <= 1'b0;
      wb_index_idx <= '0;
      wb_entry_we  <= 1'b0;
      wb_entryhi   <= '0;
      wb_entrylo0  <= '0;
      wb_entrylo1  <= '0;
    end else begin
      we           <= 1'b0;
      op_done      <= 1'b0;
      tlb_flush    <= 1'b0;
      wb_index_we  <= 1'b0;
      wb_index_p   <= 1'b0;
      wb_index_idx <= '0;
      wb_entry_we  <= 1'b0;
      wb_entryhi   <= '0;
      wb_entrylo0  <= '0;
      wb_entrylo1  <= '0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            state      <= S_EXEC;
            op_ready   <= 1'b0;
            op_q       <= tlb_op_e'(op_code);
            idx_q      <= cp0_index;
            widx_q     <= (tlb_op_e'(op_code) == OP_TLBWR) ? cp0_random : cp0_index;
            we         <= (tlb_op_e'(op_code) == OP_TLBWI) || (tlb_op_e'(op_code) == OP_TLBWR);
            ent_q.vpn2 <= cp0_entryhi[31:HI_VPN2_LSB];
            ent_q.asid <= cp0_entryhi[HI_ASID_MSB:0];
            ent_q.g    <= cp0_entrylo0[LO_G_BIT] & cp0_entrylo1[LO_G_BIT];
            ent_q.pfn0 <= cp0_entrylo0[LO_PFN_MSB:LO_PFN_LSB];
            ent_q.c0   <= cp0_entrylo0[LO_C_MSB:LO_C_LSB];
            ent_q.d0   <= cp0_entrylo0[LO_D_BIT];
            ent_q.v0   <= cp0_entrylo0[LO_V_BIT];
            ent_q.pfn1 <= cp0_entrylo1[LO_PFN_MSB:LO_PFN_LSB];
            ent_q.c1   <= cp0_entrylo1[LO_C_MSB:LO_C_LSB];
            ent_q.d1   <= cp0_entrylo1[LO_D_BIT];
            ent_q.v1   <= cp0_entrylo1[LO_V_BIT];
          end
        end
        S_EXEC: begin
          state     <= S_RESP;
          op_done   <= 1'b1;
          tlb_flush <= (op_q != OP_TLBP);
          if (op_q == OP_TLBP) begin
            wb_index_we  <= 1'b1;
            wb_index_p   <= ~s1_found;
            wb_index_idx <= s1_found ? s1_index : '0;
          end else if (op_q == OP_TLBR) begin
            wb_entry_we <= 1'b1;
            wb_entryhi  <= {r_vpn2, 5'b0, r_asid};
            wb_entrylo0 <= {6'b0, r_pfn0, r_c0, r_d0, r_v0, r_g};
            wb_entrylo1 <= {6'b0, r_pfn1, r_c1, r_d1, r_v1, r_g};
          end
        end
        S_RESP: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
        default: begin
          state    <= S_IDLE;
          op_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: behavioural TLB on the ports plus an array-level reference of TLB contents.
// Exercises the TLB_WIRED_EN path when that macro is defined.
module tb_tlb_op_ctrl;

  localparam int TLBNUM = 16;
  localparam int IW     = 4;

  logic          clk, resetn;
  logic          op_valid, op_ready, op_done, tlb_flush;
  logic [1:0]    op_code;
  logic [IW-1:0] cp0_index, cp0_random;
  logic [31:0]   cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
`ifdef TLB_WIRED_EN
  logic [IW-1:0] cp0_wired;
`endif
  logic [18:0]   s1_vpn2, w_vpn2, r_vpn2;
  logic          s1_odd_page, s1_found;
  logic [7:0]    s1_asid, w_asid, r_asid;
  logic [IW-1:0] s1_index, w_index, r_index, wb_index_idx;
  logic          we, w_g, w_d0, w_v0, w_d1, w_v1;
  logic [19:0]   w_pfn0, w_pfn1, r_pfn0, r_pfn1;
  logic [2:0]    w_c0, w_c1, r_c0, r_c1;
  logic          r_g, r_d0, r_v0, r_d1, r_v1;
  logic          wb_index_we, wb_index_p, wb_entry_we;
  logic [31:0]   wb_entryhi, wb_entrylo0, wb_entrylo1;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int we_cnt = 0;
  int done_cnt = 0;

  // TLB storage as seen through the DUT ports, and the expected contents
  logic [31:0] t_hi  [TLBNUM] = '{default: '0};
  logic [31:0] t_lo0 [TLBNUM] = '{default: '0};
  logic [31:0] t_lo1 [TLBNUM] = '{default: '0};
  logic [31:0] ref_hi  [TLBNUM];
  logic [31:0] ref_lo0 [TLBNUM];
  logic [31:0] ref_lo1 [TLBNUM];

  tlb_op_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done), .tlb_flush(tlb_flush),
    .cp0_index(cp0_index), .cp0_entryhi(cp0_entryhi),
    .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
`ifdef TLB_WIRED_EN
    .cp0_wired(cp0_wired),
`endif
    .cp0_random(cp0_random),
    .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
    .s1_found(s1_found), .s1_index(s1_index),
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_index(r_index), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .wb_index_we(wb_index_we), .wb_index_p(wb_index_p), .wb_index_idx(wb_index_idx),
    .wb_entry_we(wb_entry_we), .wb_entryhi(wb_entryhi),
    .wb_entrylo0(wb_entrylo0), .wb_entrylo1(wb_entrylo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (we) begin
      we_cnt          <= we_cnt + 1;
      t_hi[w_index]   <= {w_vpn2, 5'b0, w_asid};
      t_lo0[w_index]  <= {6'b0, w_pfn0, w_c0, w_d0, w_v0, w_g};
      t_lo1[w_index]  <= {6'b0, w_pfn1, w_c1, w_d1, w_v1, w_g};
    end
    if (op_done) done_cnt <= done_cnt + 1;
  end

  always_comb begin
    r_vpn2 = t_hi[r_index][31:13];
    r_asid = t_hi[r_index][7:0];
    r_g    = t_lo0[r_index][0];
    r_pfn0 = t_lo0[r_index][25:6];
    r_c0   = t_lo0[r_index][5:3];
    r_d0   = t_lo0[r_index][2];
    r_v0   = t_lo0[r_index][1];
    r_pfn1 = t_lo1[r_index][25:6];
    r_c1   = t_lo1[r_index][5:3];
    r_d1   = t_lo1[r_index][2];
    r_v1   = t_lo1[r_index][1];
  end

  // Search port: lowest matching entry wins
  always_comb begin
    s1_found = 1'b0;
    s1_index = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (t_hi[i][31:13] == s1_vpn2 && (t_lo0[i][0] || t_hi[i][7:0] == s1_asid)) begin
        s1_found = 1'b1;
        s1_index = IW'(i);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Random counts down from TLBNUM-1 once per cycle since reset, wrapping every TLBNUM cycles
  function automatic logic [IW-1:0] exp_rand();
    return IW'(TLBNUM - 1 - (cyc % TLBNUM));
  endfunction

  function automatic void ref_probe(input logic [31:0] hi, output logic f, output logic [IW-1:0] ix);
    f  = 1'b0;
    ix = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      if (!f && ref_hi[i][31:13] == hi[31:13] && (ref_lo0[i][0] || ref_hi[i][7:0] == hi[7:0])) begin
        f  = 1'b1;
        ix = IW'(i);
      end
    end
  endfunction

  // Entered and left at a falling edge with the controller idle
  task automatic do_op(input logic [1:0] code, input logic [IW-1:0] idx, input logic [31:0] hi,
                       input logic [31:0] lo0, input logic [31:0] lo1, input bit hold);
    logic [IW-1:0] widx, pidx;
    logic          g, pf;
    logic [31:0]   ehi, elo0, elo1;
    check("idle_ready", 32'(op_ready), 32'd1);
    widx = (code == 2'd3) ? exp_rand() : idx;
    g    = lo0[0] & lo1[0];
    ehi  = hi & 32'hFFFF_E0FF;
    elo0 = (lo0 & 32'h03FF_FFFE) | 32'(g);
    elo1 = (lo1 & 32'h03FF_FFFE) | 32'(g);
    ref_probe(hi, pf, pidx);
    op_valid = 1'b1; op_code = code; cp0_index = idx;
    cp0_entryhi = hi; cp0_entrylo0 = lo0; cp0_entrylo1 = lo1;
    @(negedge clk);
    check("exec_ready", 32'(op_ready), 32'd0);
    check("exec_done", 32'(op_done), 32'd0);
    check("exec_we", 32'(we), 32'(code[1]));
    if (code[1]) begin
      check("w_index", 32'(w_index), 32'(widx));
      check("w_hi", {w_vpn2, 5'b0, w_asid}, ehi);
      check("w_lo0", {6'b0, w_pfn0, w_c0, w_d0, w_v0, w_g}, elo0);
      check("w_lo1", {6'b0, w_pfn1, w_c1, w_d1, w_v1, w_g}, elo1);
      ref_hi[widx] = ehi; ref_lo0[widx] = elo0; ref_lo1[widx] = elo1;
    end else if (code == 2'd1) begin
      check("r_index", 32'(r_index), 32'(idx));
    end else begin
      check("s1_key", {s1_vpn2, 5'b0, s1_asid}, ehi);
      check("s1_odd", 32'(s1_odd_page), 32'd0);
    end
    if (!hold) op_valid = 1'b0;
    cp0_index = ~idx; cp0_entryhi = ~hi; op_code = ~code;
    @(negedge clk);
    check("resp_done", 32'(op_done), 32'd1);
    check("resp_we", 32'(we), 32'd0);
    check("resp_flush", 32'(tlb_flush), 32'(code != 2'd0));
    check("resp_idx_we", 32'(wb_index_we), 32'(code == 2'd0));
    check("resp_ent_we", 32'(wb_entry_we), 32'(code == 2'd1));
    if (code == 2'd0) check("probe", 32'({wb_index_p, wb_index_idx}), 32'({~pf, pidx}));
    if (code == 2'd1) begin
      check("rd_hi", wb_entryhi, ref_hi[idx]);
      check("rd_lo0", wb_entrylo0, ref_lo0[idx]);
      check("rd_lo1", wb_entrylo1, ref_lo1[idx]);
    end
    op_valid = 1'b0;
    @(negedge clk);
    check("post_done", 32'({op_done, tlb_flush, wb_index_we, wb_entry_we}), 32'd0);
  endtask

  initial begin
    int w0, d0;
    for (int i = 0; i < TLBNUM; i++) begin
      ref_hi[i] = '0; ref_lo0[i] = '0; ref_lo1[i] = '0;
    end
    resetn = 1'b0; op_valid = 1'b0; op_code = '0; cp0_index = '0;
    cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
`ifdef TLB_WIRED_EN
    cp0_wired = '0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(op_ready), 32'd1);
    check("rst_strobes", 32'({we, op_done, tlb_flush, wb_index_we, wb_entry_we}), 32'd0);
    check("rst_random", 32'(cp0_random), 32'(TLBNUM - 1));
    resetn = 1'b1;

    // TLBWR accepted in the fourth cycle after reset uses Random = TLBNUM-1-3
    repeat (3) @(negedge clk);
    do_op(2'd3, 4'd2, 32'h0800_0055, 32'h0000_2006, 32'h0000_2046, 1'b0);
    repeat (20) begin
      @(negedge clk);
      check("random", 32'(cp0_random), 32'(exp_rand()));
    end

    do_op(2'd2, 4'd5, 32'h0040_2012, 32'h0000_1007, 32'h0000_1047, 1'b0);
    do_op(2'd0, 4'd0, 32'h0040_2012, 32'h0, 32'h0, 1'b0);
    do_op(2'd2, 4'd6, 32'h0060_0012, 32'h0000_1006, 32'h0000_1046, 1'b0);
    do_op(2'd0, 4'd0, 32'h0060_0013, 32'h0, 32'h0, 1'b0);
    do_op(2'd0, 4'd0, 32'h0060_0012, 32'h0, 32'h0, 1'b0);
    do_op(2'd1, 4'd5, 32'h0, 32'h0, 32'h0, 1'b0);
    check("rd5_hi", wb_entryhi | t_hi[5], 32'h0040_2012);

    // op_valid held through EXEC/RESP must yield a single op
    w0 = we_cnt; d0 = done_cnt;
    do_op(2'd2, 4'd7, 32'h00A0_0033, 32'h0000_3017, 32'h0000_3057, 1'b1);
    @(negedge clk);
    check("hold_we_cnt", 32'(we_cnt - w0), 32'd1);
    check("hold_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Reset during EXEC drops the write and the done pulse
    d0 = done_cnt;
    op_valid = 1'b1; op_code = 2'd2; cp0_index = 4'd9;
    cp0_entryhi = 32'h00C0_0044; cp0_entrylo0 = 32'h0000_4007; cp0_entrylo1 = 32'h0000_4047;
    @(negedge clk);
    check("rst_exec_we", 32'(we), 32'd1);
    op_valid = 1'b0;
    #2 resetn = 1'b0;
    #1 check("rst_drop_we", 32'(we), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_tlb_kept", t_hi[9], ref_hi[9]);
    check("rst_random2", 32'(cp0_random), 32'(exp_rand()));

    for (int k = 0; k < 24; k++) begin
      logic [31:0] hi;
      hi = (32'($urandom_range(0, 3)) << 13) | ($urandom & 32'h0000_1F00) | 32'($urandom_range(0, 3));
      do_op(2'($urandom_range(0, 3)), IW'($urandom_range(0, TLBNUM - 1)), hi,
            $urandom, $urandom, bit'($urandom_range(0, 1)));
    end
    check("random_end", 32'(cp0_random), 32'(exp_rand()));

`ifdef TLB_WIRED_EN
    cp0_wired = 4'd4;
    @(negedge clk);
    check("wired_reload", 32'(cp0_random), 32'd15);
    repeat (100) begin
      @(negedge clk);
      check("wired_floor", 32'(cp0_random >= 4'd4), 32'd1);
    end
    cp0_wired = 4'd7;
    @(negedge clk);
    check("wired_change", 32'(cp0_random), 32'd15);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
